// File: rtl/core_sequencer_pkg.sv
// Shared constants and types for the core bus-master sequencer.
// Opcodes, FSM state encoding, instruction width and idle bus address.
package core_sequencer_pkg;

    localparam int OP_WIDTH       = 3;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int INSTR_WIDTH    = OP_WIDTH + 2 * DATA_WIDTH_DEF;

    // Address driven on the bus whenever no access is in progress.
    localparam int ADDR_IDLE = 0;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP  = 3'd0,
        OP_MOV  = 3'd1,
        OP_LDI  = 3'd2,
        OP_JMP  = 3'd3,
        OP_JZ   = 3'd4,
        OP_JNZ  = 3'd5,
        OP_HALT = 3'd6,
        OP_RSVD = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/core_sequencer_seq_decode.sv
// Combinational instruction decoder for core_sequencer.
// Ports: instr (ROM word or ir), re (ALU result) -> a/b fields,
// is_mov/is_ldi/is_halt class flags and jump_taken.
module seq_decode #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 3 + 2 * DATA_WIDTH
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0]  re,
    output logic [DATA_WIDTH-1:0]  fa,
    output logic [DATA_WIDTH-1:0]  fb,
    output logic                   is_mov,
    output logic                   is_ldi,
    output logic                   is_halt,
    output logic                   jump_taken
);

    import core_sequencer_pkg::*;

    opcode_t op;
    logic    re_zero;

    assign op      = opcode_t'(instr[INSTR_WIDTH-1 -: OP_WIDTH]);
    assign fa      = instr[INSTR_WIDTH-OP_WIDTH-1 -: DATA_WIDTH];
    assign fb      = instr[DATA_WIDTH-1:0];
    assign re_zero = (re == '0);

    always_comb begin
        is_mov     = 1'b0;
        is_ldi     = 1'b0;
        is_halt    = 1'b0;
        jump_taken = 1'b0;
        case (op)
            OP_MOV:  is_mov     = 1'b1;
            OP_LDI:  is_ldi     = 1'b1;
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = re_zero;
            OP_JNZ:  jump_taken = !re_zero;
            OP_HALT: is_halt    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Bus-master sequencer: fetches move-style instructions from a sync ROM
// and drives the core address/write-data buses with read/write strobes.
// Ports: clk, rst (sync, active-high), start, busy, halted, rom_addr,
// rom_data, addr_bus, bus_re, bus_we, data_bus_in, data_bus_out, re, pc.
module core_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ROM_ADDR_WIDTH = 8,
    parameter int INSTR_WIDTH    = 3 + 2 * DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      halted,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [INSTR_WIDTH-1:0]    rom_data,
    output logic [DATA_WIDTH-1:0]     addr_bus,
    output logic                      bus_re,
    output logic                      bus_we,
    output logic [DATA_WIDTH-1:0]     data_bus_in,
    input  logic [DATA_WIDTH-1:0]     data_bus_out,
    input  logic [DATA_WIDTH-1:0]     re,
    output logic [ROM_ADDR_WIDTH-1:0] pc
);

    import core_sequencer_pkg::*;

    localparam logic [ROM_ADDR_WIDTH-1:0] PC_ONE = 1;
    localparam logic [DATA_WIDTH-1:0] BUS_IDLE = DATA_WIDTH'(ADDR_IDLE);

    state_t                  state;
    logic [INSTR_WIDTH-1:0]  ir;
    logic [DATA_WIDTH-1:0]   mdr;
    logic [INSTR_WIDTH-1:0]  dec_instr;
    logic [DATA_WIDTH-1:0]   fa;
    logic [DATA_WIDTH-1:0]   fb;
    logic                    is_mov;
    logic                    is_ldi;
    logic                    is_halt;
    logic                    jump_taken;

    // rom_data is only valid in EXEC; later states work from ir.
    assign dec_instr = (state == ST_EXEC) ? rom_data : ir;

    seq_decode #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_decode (
        .instr      (dec_instr),
        .re         (re),
        .fa         (fa),
        .fb         (fb),
        .is_mov     (is_mov),
        .is_ldi     (is_ldi),
        .is_halt    (is_halt),
        .jump_taken (jump_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ir     <= '0;
            mdr    <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_FETCH;
                        halted <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    ir <= rom_data;
                    unique case (1'b1)
                        is_mov: begin
                            mdr   <= data_bus_out;
                            state <= ST_WRITE;
                        end
                        is_ldi: begin
                            mdr   <= fa;
                            state <= ST_WRITE;
                        end
                        jump_taken: begin
                            pc    <= fa[ROM_ADDR_WIDTH-1:0];
                            state <= ST_FETCH;
                        end
                        is_halt: begin
                            pc     <= pc + PC_ONE;
                            halted <= 1'b1;
                            state  <= ST_IDLE;
                        end
                        default: begin
                            pc    <= pc + PC_ONE;
                            state <= ST_FETCH;
                        end
                    endcase
                end
                ST_WRITE: begin
                    pc    <= pc + PC_ONE;
                    state <= ST_FETCH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus decodes follow the registered state; in EXEC they also follow
    // rom_data, which the synchronous ROM updates on the same edge.
    always_comb begin
        addr_bus    = BUS_IDLE;
        bus_re      = 1'b0;
        bus_we      = 1'b0;
        data_bus_in = '0;
        case (state)
            ST_EXEC: begin
                if (is_mov) begin
                    addr_bus = fa;
                    bus_re   = 1'b1;
                end
            end
            ST_WRITE: begin
                addr_bus    = fb;
                bus_we      = 1'b1;
                data_bus_in = mdr;
            end
            default: ;
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign rom_addr = pc;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer with a sync ROM and RAM model.
// Table-driven program trace plus directed jump/halt/reset sequences.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        halted;
    logic [7:0]  rom_addr;
    logic [18:0] rom_data;
    logic [7:0]  addr_bus;
    logic        bus_re;
    logic        bus_we;
    logic [7:0]  data_bus_in;
    logic [7:0]  data_bus_out;
    logic [7:0]  re;
    logic [7:0]  pc;

    logic [18:0] rom [256];
    logic [7:0]  mem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .halted       (halted),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .addr_bus     (addr_bus),
        .bus_re       (bus_re),
        .bus_we       (bus_we),
        .data_bus_in  (data_bus_in),
        .data_bus_out (data_bus_out),
        .re           (re),
        .pc           (pc)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) if (bus_we) mem[addr_bus] <= data_bus_in;
    assign data_bus_out = mem[addr_bus];

    function automatic logic [18:0] ins(
        input logic [2:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        return {op, a, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " halted"}, halted, 0);
        chk({tag, " rom_addr"}, rom_addr, 0);
        chk({tag, " addr_bus"}, addr_bus, 0);
        chk({tag, " bus_re"}, bus_re, 0);
        chk({tag, " bus_we"}, bus_we, 0);
        chk({tag, " data_bus_in"}, data_bus_in, 0);
        chk({tag, " pc"}, pc, 0);
    endtask

    typedef struct {
        logic       start;
        logic       busy;
        logic       halted;
        logic [7:0] addr;
        logic       bre;
        logic       bwe;
        logic [7:0] din;
        logic [7:0] pc;
    } vec_t;

    vec_t tv [9];

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = '0;
            mem[i] = '0;
        end
        rom[0]   = ins(3'd2, 8'h2A, 8'h10);
        rom[1]   = ins(3'd1, 8'h10, 8'h20);
        rom[2]   = ins(3'd6, 8'h00, 8'h00);
        rom[3]   = ins(3'd4, 8'h05, 8'h00);
        rom[5]   = ins(3'd6, 8'h00, 8'h00);
        rom[6]   = ins(3'd4, 8'h05, 8'h00);
        rom[7]   = ins(3'd6, 8'h00, 8'h00);
        rom[8]   = ins(3'd3, 8'hFF, 8'h00);
        rom[255] = ins(3'd0, 8'h00, 8'h00);

        // start, busy, halted, addr, re, we, din, pc
        tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tv[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        tv[2] = '{1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 8'h2A, 8'h00};
        tv[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01};
        tv[4] = '{1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'h00, 8'h01};
        tv[5] = '{1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 8'h2A, 8'h01};
        tv[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02};
        tv[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02};
        tv[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03};

        rst   = 1'b1;
        start = 1'b0;
        re    = 8'h00;

        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom_range(0, 1));
            step();
            chk_reset_outputs("rst_hold");
        end
        start = 1'b1;
        step();
        chk_reset_outputs("rst_with_start");
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk_reset_outputs("post_rst");

        for (int i = 0; i < 9; i++) begin
            start = tv[i].start;
            step();
            chk($sformatf("prog c%0d busy", i), busy, tv[i].busy);
            chk($sformatf("prog c%0d halted", i), halted, tv[i].halted);
            chk($sformatf("prog c%0d addr", i), addr_bus, tv[i].addr);
            chk($sformatf("prog c%0d bus_re", i), bus_re, tv[i].bre);
            chk($sformatf("prog c%0d bus_we", i), bus_we, tv[i].bwe);
            chk($sformatf("prog c%0d din", i), data_bus_in, tv[i].din);
            chk($sformatf("prog c%0d pc", i), pc, tv[i].pc);
        end
        start = 1'b0;
        chk("mem20_after_mov", mem[8'h20], 8'h2A);

        // Restart after HALT into JZ taken (re == 0).
        re    = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart halted_clear", halted, 0);
        chk("restart busy", busy, 1);
        chk("restart fetch rom_addr", rom_addr, 3);
        step();
        chk("jz_taken exec re", bus_re, 0);
        chk("jz_taken exec we", bus_we, 0);
        step();
        chk("jz_taken pc", pc, 5);
        chk("jz_taken rom_addr", rom_addr, 5);
        step();
        step();
        chk("halt2 busy", busy, 0);
        chk("halt2 halted", halted, 1);
        chk("halt2 pc", pc, 6);

        // JZ not taken (re != 0).
        re    = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("jz_nt exec we", bus_we, 0);
        step();
        chk("jz_nt pc", pc, 7);
        step();
        step();
        chk("halt3 halted", halted, 1);
        chk("halt3 pc", pc, 8);

        // Jump to last ROM address, NOP there, wrap to 0.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("jmp_ff pc", pc, 8'hFF);
        chk("jmp_ff rom_addr", rom_addr, 8'hFF);
        step();
        step();
        chk("wrap pc", pc, 0);
        chk("wrap rom_addr", rom_addr, 0);
        chk("wrap busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("rst_after_wrap");

        // Reset during EXEC of a MOV drops the write.
        rom[0] = ins(3'd1, 8'h10, 8'h30);
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mov_exec bus_re", bus_re, 1);
        chk("mov_exec addr", addr_bus, 8'h10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("rst_mid_mov");
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("dropped_write c%0d we", i), bus_we, 0);
        end
        chk("mem30_untouched", mem[8'h30], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Bus-master sequencer for the microcontroller core datapath. It fetches move-style instructions from a synchronous program ROM and drives the core's shared address bus and write-data bus. Each datapath transfer is a read of one addressed resource (ALU result, common register, address register, RAM) followed by a write to another. It also handles immediate loads, jumps on the ALU result, and halt/restart. It sits above `core`: its `addr_bus` and `data_bus_in` feed the core, and the core's `data_bus_out` and `re` feed back into it.

## Interface
Parameters:
- DATA_WIDTH, 8, bus and ALU result width
- ROM_ADDR_WIDTH, 8, program counter / ROM address width; must be ≤ DATA_WIDTH
- INSTR_WIDTH, 3+2*DATA_WIDTH, ROM word width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begins execution at the current pc; only honoured in IDLE
- busy  out  1  high in every state except IDLE
- halted  out  1  high in IDLE after a HALT instruction; cleared by start or rst
- rom_addr  out  ROM_ADDR_WIDTH  program ROM address
- rom_data  in  INSTR_WIDTH  ROM word, valid one cycle after rom_addr is presented
- addr_bus  out  DATA_WIDTH  core address bus; 0 (idle address) when no bus access is in progress
- bus_re  out  1  read strobe; core data_bus_out is sampled this cycle
- bus_we  out  1  write strobe; the addressed resource latches data_bus_in this cycle
- data_bus_in  out  DATA_WIDTH  write data to core; 0 when bus_we is low
- data_bus_out  in  DATA_WIDTH  core read data, combinational from addr_bus
- re  in  DATA_WIDTH  current ALU result, used for conditional jumps
- pc  out  ROM_ADDR_WIDTH  program counter, for debug

## Operation
- Instruction fields are op = rom_data[INSTR_WIDTH-1 -: 3], a = next DATA_WIDTH bits, b = low DATA_WIDTH bits.
- Opcodes:
  - 0 NOP
  - 1 MOV: read a, write b
  - 2 LDI: write immediate a to address b
  - 3 JMP a
  - 4 JZ a: jump if re == 0
  - 5 JNZ a: jump if re != 0
  - 6 HALT
  - 7 reserved; executes as NOP
- States:
  - IDLE --start--> FETCH
  - FETCH drives rom_addr = pc and goes to EXEC.
  - EXEC latches rom_data into ir and performs the op:
    - MOV: addr_bus = a, bus_re = 1, mdr <= data_bus_out, go to WRITE.
    - LDI: mdr <= a, go to WRITE.
    - JMP, or JZ/JNZ taken: pc <= a[ROM_ADDR_WIDTH-1:0], go to FETCH.
    - JZ/JNZ not taken, or NOP: pc <= pc+1, go to FETCH.
    - HALT: pc <= pc+1, halted <= 1, go to IDLE.
  - WRITE: addr_bus = ir.b, data_bus_in = mdr, bus_we = 1, pc <= pc+1, go to FETCH.
- pc increments modulo 2^ROM_ADDR_WIDTH; 2^ROM_ADDR_WIDTH-1 wraps to 0.
- Jump targets use the low ROM_ADDR_WIDTH bits of a.
- MOV with a == b is legal: the resource is read, then the same value is written back.
- Address 0 is reserved as the idle address; instructions that target 0 still drive it with the strobe asserted.
- start while busy is ignored. start and rst in the same cycle: rst wins.
- rst in any state, including mid-MOV between EXEC and WRITE, returns to IDLE with no further bus strobe. The interrupted write is dropped.

## Timing
- Reset values: state IDLE, pc 0, ir 0, mdr 0, busy 0, halted 0, rom_addr 0, addr_bus 0, bus_re 0, bus_we 0, data_bus_in 0.
- Bus outputs are registered-state decodes. addr_bus, bus_re, bus_we and data_bus_in change only on the state transition edge and are stable for the whole cycle.
- Cycles per instruction: MOV 3, LDI 3, jumps/NOP 2, HALT 2. busy goes high the cycle after start.
- bus_re and bus_we are never high in the same cycle. Each is high for exactly one cycle per MOV/LDI.
- The ROM must be synchronous with 1-cycle latency. rom_data is sampled only in EXEC.

## Structure
- In the shared define header: opcode constants (OP_NOP…OP_HALT), state encoding (ST_IDLE, ST_FETCH, ST_EXEC, ST_WRITE), INSTR_WIDTH and ADDR_IDLE.
- One natural sub-module: `seq_decode`, combinational. It takes ir/rom_data and re, and outputs field slices, is_mov/is_ldi/is_halt, and jump_taken. Everything else lives in core_sequencer.

## Test plan
- Reset hold with random start pulses: all outputs equal their reset values; start during rst has no effect.
- Program LDI 0x2A→0x10, MOV 0x10→0x20, HALT: cycle 2 bus_we with addr 0x10 / data 0x2A; cycle 4 bus_re with addr 0x10; cycle 5 bus_we with addr 0x20 / data 0x2A; halted=1, pc=3.
- JZ 0x05 with re=0: pc becomes 5, two cycles, no strobes. Repeated with re=1: pc becomes pc+1.
- HALT, then start pulse: execution resumes at the instruction after HALT and halted clears the cycle after start.
- JMP to 2^ROM_ADDR_WIDTH-1 holding NOP: pc wraps to 0 and fetches address 0.
- rst asserted during the EXEC cycle of a MOV: no bus_we in any following cycle; IDLE and pc=0 on the next cycle.
